// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing generator with four test patterns.
// Ports: clk, reset_n, enable, mode[1:0] in; hsync, vsync, display_on, hpos, vpos, rgb, frame_start, frame_count out (all registered).
module vga_pattern_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CW        = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [1:0]      mode,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic [10:0]     hpos,
  output logic [10:0]     vpos,
  output logic [3*CW-1:0] rgb,
  output logic            frame_start,
  output logic [7:0]      frame_count
);

  localparam int unsigned HT =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned BAR_W = H_DISPLAY / 8;

  localparam logic [10:0] H_MAX  = 11'(HT - 1);
  localparam logic [10:0] V_MAX  = 11'(VT - 1);
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END =
    11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END =
    11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

  logic [10:0]     h_q, h_d;
  logic [10:0]     v_q, v_d;
  logic [10:0]     bar_px_q, bar_px_d;
  logic [2:0]      bar_q, bar_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      fc_q, fc_d;

  logic [10:0]     hpos_q, vpos_q;
  logic            hs_q, vs_q, de_q, fs_q;
  logic [3*CW-1:0] rgb_q, rgb_d;

  logic            frame_top;
  logic            h_wrap;
  logic            vis_d, hs_d, vs_d;
  logic [10:0]     ramp;
  logic [CW-1:0]   r_d, g_d, b_d;

  always_comb begin
    frame_top = (h_q == 11'd0) && (v_q == 11'd0);
    // Mode and frame count switch on the frame's first pixel,
    // so that pixel already shows the new values.
    mode_d = frame_top ? mode : mode_q;
    fc_d   = frame_top ? fc_q + 8'd1 : fc_q;

    h_wrap = (h_q == H_MAX);
    h_d    = h_wrap ? 11'd0 : h_q + 11'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_MAX) ? 11'd0 : v_q + 11'd1;
    end

    // Bar index tracks h without a divider; saturates at 7.
    bar_px_d = bar_px_q + 11'd1;
    bar_d    = bar_q;
    if (h_wrap) begin
      bar_px_d = 11'd0;
      bar_d    = 3'd0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d = 11'd0;
      if (bar_q != 3'd7) begin
        bar_d = bar_q + 3'd1;
      end
    end

    vis_d = (h_q < H_VIS) && (v_q < V_VIS);
    hs_d  = (h_q >= HS_BEG && h_q <= HS_END) ?
            SYNC_POL : ~SYNC_POL;
    vs_d  = (v_q >= VS_BEG && v_q <= VS_END) ?
            SYNC_POL : ~SYNC_POL;

    ramp = h_q + {3'b000, fc_d};
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    unique case (1'b1)
      mode_d == 2'd0: begin
        r_d = {CW{(h_q[2:0] == 3'd0) ||
                  (v_q[2:0] == 3'd0)}};
        g_d = {CW{v_q[4]}};
        b_d = {CW{h_q[4]}};
      end
      mode_d == 2'd1: begin
        r_d = {CW{bar_q[0]}};
        g_d = {CW{bar_q[1]}};
        b_d = {CW{bar_q[2]}};
      end
      mode_d == 2'd2: begin
        r_d = {CW{h_q[5] ^ v_q[5]}};
        g_d = {CW{h_q[5] ^ v_q[5]}};
        b_d = {CW{h_q[5] ^ v_q[5]}};
      end
      default: begin
        r_d = CW'(ramp >> 4);
        g_d = CW'(v_q >> 4);
        b_d = CW'(fc_d);
      end
    endcase
    rgb_d = vis_d ? {b_d, g_d, r_d} : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= '0;
      v_q      <= '0;
      bar_px_q <= '0;
      bar_q    <= '0;
      mode_q   <= '0;
      fc_q     <= '0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      de_q     <= 1'b0;
      rgb_q    <= '0;
      fs_q     <= 1'b0;
    end else if (enable) begin
      h_q      <= h_d;
      v_q      <= v_d;
      bar_px_q <= bar_px_d;
      bar_q    <= bar_d;
      mode_q   <= mode_d;
      fc_q     <= fc_d;
      hpos_q   <= h_q;
      vpos_q   <= v_q;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= vis_d;
      rgb_q    <= rgb_d;
      fs_q     <= frame_top;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign display_on  = de_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed vector bench for vga_pattern_gen.
// Small timing (72x44, CW=2) keeps frames short.
module tb_vga_pattern_gen;

  localparam int HT    = 72;
  localparam int VT    = 44;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic        hsync, vsync, display_on;
  logic [10:0] hpos, vpos;
  logic [5:0]  rgb;
  logic        frame_start;
  logic [7:0]  frame_count;

  vga_pattern_gen #(
    .H_DISPLAY(64), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(40), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0), .CW(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .hsync(hsync),
    .vsync(vsync),
    .display_on(display_on),
    .hpos(hpos),
    .vpos(vpos),
    .rgb(rgb),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    int         h;
    int         v;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       de;
  } vec_t;

  vec_t tbl[$];
  int   nchk = 0;
  int   nerr = 0;
  int   ecyc = 0;

  function automatic int mp();
    return (ecyc - 1) % FRAME;
  endfunction

  function automatic int mfc();
    return ((ecyc - 1) / FRAME + 1) % 256;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", n, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input int h,
                     input int v, input logic [5:0] c,
                     input logic hs, input logic vs,
                     input logic de);
    vec_t e;
    e.m = m; e.h = h; e.v = v; e.rgb = c;
    e.hs = hs; e.vs = vs; e.de = de;
    tbl.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (enable) ecyc++;
  endtask

  task automatic goto(input int h, input int v);
    int t = v * HT + h;
    int n = 0;
    while (!(ecyc >= 1 && mp() == t) && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (n >= 2 * FRAME) begin
      nchk++;
      nerr++;
      $display("FAIL goto %0d,%0d: not reached in %0d cycles",
               h, v, n);
    end
  endtask

  task automatic next_frame();
    step();
    goto(0, 0);
  endtask

  initial begin
    int cur_mode;
    int cnt;
    int first_h;
    int first_v;
    int n;

    // mode, h, v, rgb {b,g,r}, hsync, vsync, display_on
    add(0,  0,  0, 6'b000011, 1, 1, 1);
    add(0,  5,  3, 6'b000000, 1, 1, 1);
    add(0, 16,  8, 6'b110011, 1, 1, 1);
    add(0, 64, 10, 6'b000000, 1, 1, 0);
    add(0, 66, 10, 6'b000000, 0, 1, 0);
    add(0, 69, 10, 6'b000000, 0, 1, 0);
    add(0, 70, 10, 6'b000000, 1, 1, 0);
    add(0, 17, 17, 6'b111100, 1, 1, 1);
    add(0, 63, 39, 6'b110000, 1, 1, 1);
    add(0, 10, 41, 6'b000000, 1, 0, 0);
    add(0, 10, 43, 6'b000000, 1, 1, 0);
    add(1,  0,  5, 6'b000000, 1, 1, 1);
    add(1,  7,  5, 6'b000000, 1, 1, 1);
    add(1,  8,  5, 6'b000011, 1, 1, 1);
    add(1, 23,  5, 6'b001100, 1, 1, 1);
    add(1, 24,  5, 6'b001111, 1, 1, 1);
    add(1, 39,  5, 6'b110000, 1, 1, 1);
    add(1, 47,  5, 6'b110011, 1, 1, 1);
    add(1, 48,  5, 6'b111100, 1, 1, 1);
    add(1, 63,  5, 6'b111111, 1, 1, 1);
    add(1, 64,  5, 6'b000000, 1, 1, 0);
    add(2,  0,  0, 6'b000000, 1, 1, 1);
    add(2, 31,  0, 6'b000000, 1, 1, 1);
    add(2, 32,  0, 6'b111111, 1, 1, 1);
    add(2, 32, 32, 6'b000000, 1, 1, 1);
    add(2,  5, 33, 6'b111111, 1, 1, 1);
    add(3,  0,  0, 6'b000000, 1, 1, 1);
    add(3, 12,  0, 6'b000001, 1, 1, 1);
    add(3, 60, 20, 6'b000100, 1, 1, 1);
    add(3, 40, 35, 6'b001010, 1, 1, 1);

    reset_n = 1'b0;
    enable  = 1'b1;
    mode    = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst hsync", hsync, 1);
    chk("rst vsync", vsync, 1);
    chk("rst de", display_on, 0);
    chk("rst rgb", rgb, 0);
    chk("rst fs", frame_start, 0);
    chk("rst hpos", hpos, 0);
    chk("rst vpos", vpos, 0);
    chk("rst fc", frame_count, 0);
    reset_n = 1'b1;
    ecyc = 0;

    cur_mode = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (int'(tbl[i].m) != cur_mode) begin
        mode = tbl[i].m;
        cur_mode = int'(tbl[i].m);
        next_frame();
      end
      goto(tbl[i].h, tbl[i].v);
      chk($sformatf("v%0d hpos", i), hpos, tbl[i].h);
      chk($sformatf("v%0d vpos", i), vpos, tbl[i].v);
      chk($sformatf("v%0d rgb", i), rgb, tbl[i].rgb);
      chk($sformatf("v%0d hsync", i), hsync, tbl[i].hs);
      chk($sformatf("v%0d vsync", i), vsync, tbl[i].vs);
      chk($sformatf("v%0d de", i), display_on, tbl[i].de);
      chk($sformatf("v%0d fc", i), frame_count, mfc());
      chk($sformatf("v%0d fs", i), frame_start, mp() == 0);
    end

    // Frame period and frame counter in ramp mode (frame 5 -> 6).
    next_frame();
    chk("f5 fs", frame_start, 1);
    chk("f5 fc", frame_count, 5);
    chk("f5 b", rgb[5:4], 2'b01);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    chk("frame period", n, FRAME);
    chk("f6 fc", frame_count, 6);
    chk("f6 b", rgb[5:4], 2'b10);

    // One line of hsync.
    goto(0, 5);
    cnt = 0;
    first_h = -1;
    for (int i = 0; i < HT; i++) begin
      if (hsync === 1'b0) begin
        cnt++;
        if (first_h < 0) first_h = int'(hpos);
      end
      step();
    end
    chk("hsync width", cnt, 4);
    chk("hsync start", first_h, 66);
    chk("line hpos", hpos, 0);
    chk("line vpos", vpos, 6);

    // One frame of vsync.
    next_frame();
    cnt = 0;
    first_h = -1;
    first_v = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (vsync === 1'b0) begin
        cnt++;
        if (first_v < 0) begin
          first_v = int'(vpos);
          first_h = int'(hpos);
        end
      end
      step();
    end
    chk("vsync width", cnt, 2 * HT);
    chk("vsync vstart", first_v, 41);
    chk("vsync hstart", first_h, 0);
    chk("f8 fs", frame_start, 1);
    chk("f8 fc", frame_count, 8);

    // Enable pause mid-line.
    goto(30, 7);
    chk("pre hpos", hpos, 30);
    chk("pre rgb", rgb, 6'b000010);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold%0d hpos", i), hpos, 30);
      chk($sformatf("hold%0d vpos", i), vpos, 7);
      chk($sformatf("hold%0d rgb", i), rgb, 6'b000010);
      chk($sformatf("hold%0d de", i), display_on, 1);
      chk($sformatf("hold%0d fs", i), frame_start, 0);
      chk($sformatf("hold%0d fc", i), frame_count, 8);
    end
    enable = 1'b1;
    step();
    chk("resume hpos", hpos, 31);
    chk("resume rgb", rgb, 6'b000010);
    goto(0, 8);
    chk("after pause hpos", hpos, 0);
    chk("after pause vpos", vpos, 8);

    // Mode changes mid-frame only apply next frame.
    goto(32, 21);
    chk("ramp 32,21", rgb, 6'b000110);
    mode = 2'd0;
    goto(32, 30);
    chk("ramp kept", rgb, 6'b000110);
    next_frame();
    chk("grid f9", rgb, 6'b000011);
    chk("f9 fc", frame_count, 9);
    goto(0, 20);
    chk("grid 0,20", rgb, 6'b001111);
    mode = 2'd2;
    goto(32, 21);
    chk("grid kept", rgb, 6'b001111);
    next_frame();
    chk("chk 0,0", rgb, 6'b000000);
    chk("f10 fs", frame_start, 1);
    goto(32, 0);
    chk("chk 32,0", rgb, 6'b111111);

    // Asynchronous reset between clock edges.
    goto(40, 20);
    chk("pre rst hpos", hpos, 40);
    chk("pre rst rgb", rgb, 6'b111111);
    #2;
    reset_n = 1'b0;
    mode = 2'd0;
    #1;
    chk("arst hpos", hpos, 0);
    chk("arst vpos", vpos, 0);
    chk("arst hsync", hsync, 1);
    chk("arst vsync", vsync, 1);
    chk("arst de", display_on, 0);
    chk("arst rgb", rgb, 0);
    chk("arst fs", frame_start, 0);
    chk("arst fc", frame_count, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("held hpos", hpos, 0);
    reset_n = 1'b1;
    ecyc = 0;
    step();
    chk("restart hpos", hpos, 0);
    chk("restart vpos", vpos, 0);
    chk("restart fs", frame_start, 1);
    chk("restart fc", frame_count, 1);
    chk("restart rgb", rgb, 6'b000011);
    step();
    chk("restart2 hpos", hpos, 1);
    chk("restart2 fs", frame_start, 0);
    chk("restart2 rgb", rgb, 6'b000011);

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

endmodule
